// File: rtl/ahb_isram_pkg.sv
// Shared AHB-Lite encodings and the byte-lane decode used by the on-chip SRAM bridge.
package ahb_isram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Sizes above a word cannot be narrower than the 32-bit bus, so they enable all lanes.
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_isram_bridge.sv
// Zero-wait-state AHB-Lite slave driving a pipelined-read, byte-enabled-write SRAM macro.
// Writes that collide with a read are parked in a one-entry buffer and forwarded to later reads.
module ahb_isram_bridge
  import ahb_isram_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW+1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);

  logic          trans_valid, rd_req, wr_req;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_mask;

  logic          wr_dphase_q, wr_dphase_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]    wr_mask_q, wr_mask_d;
  logic          buf_pend_q, buf_pend_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]    buf_mask_q, buf_mask_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [3:0]    fwd_mask_q, fwd_mask_d;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign trans_valid = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign rd_req      = trans_valid & ~HWRITE;
  assign wr_req      = trans_valid & HWRITE;
  assign req_addr    = HADDR[AW+1:2];
  assign req_mask    = byte_mask(HSIZE, HADDR[1:0]);

  // A write data phase can only be parked while the buffer is empty: a pending entry always
  // commits in the preceding (non-read) write address phase, so the two never overlap.
  always_comb begin
    wr_dphase_d = wr_req;
    wr_addr_d   = wr_addr_q;
    wr_mask_d   = wr_mask_q;
    buf_pend_d  = buf_pend_q;
    buf_addr_d  = buf_addr_q;
    buf_mask_d  = buf_mask_q;
    buf_data_d  = buf_data_q;
    fwd_mask_d  = fwd_mask_q;

    if (wr_req) begin
      wr_addr_d = req_addr;
      wr_mask_d = req_mask;
    end

    if (wr_dphase_q && rd_req) begin
      buf_pend_d = 1'b1;
      buf_addr_d = wr_addr_q;
      buf_mask_d = wr_mask_q;
      buf_data_d = HWDATA;
    end else if (buf_pend_q && !rd_req) begin
      buf_pend_d = 1'b0;
    end

    if (rd_req) begin
      if (wr_dphase_q && (wr_addr_q == req_addr))
        fwd_mask_d = wr_mask_q;
      else if (buf_pend_q && (buf_addr_q == req_addr))
        fwd_mask_d = buf_mask_q;
      else
        fwd_mask_d = 4'b0000;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_dphase_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_mask_q   <= 4'b0000;
      buf_pend_q  <= 1'b0;
      buf_addr_q  <= '0;
      buf_mask_q  <= 4'b0000;
      buf_data_q  <= 32'h0;
      fwd_mask_q  <= 4'b0000;
    end else begin
      wr_dphase_q <= wr_dphase_d;
      wr_addr_q   <= wr_addr_d;
      wr_mask_q   <= wr_mask_d;
      buf_pend_q  <= buf_pend_d;
      buf_addr_q  <= buf_addr_d;
      buf_mask_q  <= buf_mask_d;
      buf_data_q  <= buf_data_d;
      fwd_mask_q  <= fwd_mask_d;
    end
  end

  // Reads own the port; a parked write goes next, and an unobstructed data phase writes straight through.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = buf_addr_q;
    SRAMWDATA = buf_data_q;
    if (!HRESETn) begin
      SRAMCS = 1'b0;
    end else if (rd_req) begin
      SRAMCS   = 1'b1;
      SRAMADDR = req_addr;
    end else if (buf_pend_q) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = buf_mask_q;
      SRAMADDR  = buf_addr_q;
      SRAMWDATA = buf_data_q;
    end else if (wr_dphase_q) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = wr_mask_q;
      SRAMADDR  = wr_addr_q;
      SRAMWDATA = HWDATA;
    end
  end

  always_comb begin
    HRDATA = SRAMRDATA;
    for (int n = 0; n < 4; n++) begin
      if (fwd_mask_q[n]) HRDATA[8*n +: 8] = buf_data_q[8*n +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_isram_bridge.sv
// Directed bench for ahb_isram_bridge: per-cycle vector table plus a reset-abort sequence.
module tb_ahb_isram_bridge;
  import ahb_isram_pkg::*;

  localparam int AW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL, HREADY, HWRITE;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [AW+1:0] HADDR;
  logic [31:0]   HWDATA;
  logic          HREADYOUT, HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWEN;
  logic          SRAMCS;
  logic [31:0]   SRAMRDATA;

  ahb_isram_bridge #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS),
    .SRAMRDATA(SRAMRDATA)
  );

  always #5 HCLK = ~HCLK;

  // SRAM macro model: registered read data, byte-enabled write, preset contents on first edge.
  logic [31:0] mem [0:1023];
  logic [31:0] srd = 32'h0;
  bit          init_done = 1'b0;
  int          nwrites = 0;
  assign SRAMRDATA = srd;

  always @(posedge HCLK) begin
    if (!init_done) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
      mem[12'h00C] <= 32'h55555555;
      mem[12'h014] <= 32'h12345678;
      mem[12'h01C] <= 32'h0BADF00D;
      init_done <= 1'b1;
    end else if (SRAMCS) begin
      if (|SRAMWEN) begin
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) mem[SRAMADDR[9:0]][8*b +: 8] <= SRAMWDATA[8*b +: 8];
        nwrites <= nwrites + 1;
      end else begin
        srd <= mem[SRAMADDR[9:0]];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          sel, rdy, wr, cs, chk_rd;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [17:0] addr;
    logic [31:0] wd, swd, rd;
    logic [3:0]  wen;
    logic [15:0] sa;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit sel, input bit rdy, input logic [1:0] tr, input bit wr,
                              input logic [2:0] sz, input logic [17:0] a, input logic [31:0] wd,
                              input bit cs, input logic [3:0] wen, input logic [15:0] sa,
                              input logic [31:0] swd, input bit chk_rd, input logic [31:0] rd);
    vec_t v;
    v.sel = sel; v.rdy = rdy; v.tr = tr; v.wr = wr; v.sz = sz; v.addr = a; v.wd = wd;
    v.cs = cs; v.wen = wen; v.sa = sa; v.swd = swd; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  task automatic drive(input bit sel, input bit rdy, input logic [1:0] tr, input bit wr,
                       input logic [2:0] sz, input logic [17:0] a, input logic [31:0] wd);
    HSEL = sel; HREADY = rdy; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a; HWDATA = wd;
  endtask

  localparam logic [1:0] ID = HTRANS_IDLE, BZ = HTRANS_BUSY, NS = HTRANS_NONSEQ, SQ = HTRANS_SEQ;
  localparam logic [2:0] SB = HSIZE_BYTE, SH = HSIZE_HALF, SW = HSIZE_WORD;

  initial begin
    int nw0;
    HRESETn = 1'b0;
    drive(0, 1, ID, 0, SW, '0, 32'h0);

    // Each row is one cycle: address phase inputs, HWDATA for the previous write, SRAM pins, HRDATA.
    tbl.push_back(mk(1,1,NS,1,SW,18'h10,32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'hDEADBEEF, 1,4'hF,16'h4, 32'hDEADBEEF, 0,32'h0));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,1,SW,18'h20,32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,0,SW,18'h20,32'h11223344, 1,4'h0,16'h8, 32'h0,        0,32'h0));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        1,4'hF,16'h8, 32'h11223344, 1,32'h11223344));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,0,SW,18'h20,32'h0,        1,4'h0,16'h8, 32'h0,        0,32'h0));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        0,4'h0,16'h0, 32'h0,        1,32'h11223344));
    tbl.push_back(mk(1,1,NS,1,SB,18'h31,32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,0,SW,18'h30,32'h0000AB00, 1,4'h0,16'hC, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,SQ,0,SW,18'h30,32'h0,        1,4'h0,16'hC, 32'h0,        1,32'h5555AB55));
    tbl.push_back(mk(1,1,SQ,0,SW,18'h30,32'h0,        1,4'h0,16'hC, 32'h0,        1,32'h5555AB55));
    tbl.push_back(mk(1,1,SQ,0,SW,18'h30,32'h0,        1,4'h0,16'hC, 32'h0,        1,32'h5555AB55));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        1,4'h2,16'hC, 32'h0000AB00, 1,32'h5555AB55));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,1,SW,18'h40,32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,1,SW,18'h44,32'hA,        1,4'hF,16'h10,32'hA,        0,32'h0));
    tbl.push_back(mk(1,1,NS,0,SW,18'h40,32'hB,        1,4'h0,16'h10,32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,0,SW,18'h44,32'h0,        1,4'h0,16'h11,32'h0,        1,32'hA));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        1,4'hF,16'h11,32'hB,        1,32'hB));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,1,SH,18'h52,32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,0,SW,18'h50,32'hCAFE0000, 1,4'h0,16'h14,32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,BZ,0,SW,18'h60,32'h0,        1,4'hC,16'h14,32'hCAFE0000, 1,32'hCAFE5678));
    tbl.push_back(mk(0,1,NS,0,SW,18'h60,32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,BZ,0,SW,18'h60,32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,0,NS,0,SW,18'h60,32'h0,        0,4'h0,16'h0, 32'h0,        0,32'h0));
    tbl.push_back(mk(1,1,NS,0,SW,18'h50,32'h0,        1,4'h0,16'h14,32'h0,        0,32'h0));
    tbl.push_back(mk(0,1,ID,0,SW,18'h0, 32'h0,        0,4'h0,16'h0, 32'h0,        1,32'hCAFE5678));

    repeat (2) @(posedge HCLK);
    #1;
    chk("rst.hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("rst.hresp",     {31'h0, HRESP},     32'h0);
    chk("rst.sramcs",    {31'h0, SRAMCS},    32'h0);
    chk("rst.sramwen",   {28'h0, SRAMWEN},   32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst.hrdata_known", {31'h0, $isunknown(HRDATA)}, 32'h0);

    foreach (tbl[i]) begin
      @(posedge HCLK);
      #1;
      drive(tbl[i].sel, tbl[i].rdy, tbl[i].tr, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wd);
      @(negedge HCLK);
      chk($sformatf("v%0d.cs", i),  {31'h0, SRAMCS},  {31'h0, tbl[i].cs});
      chk($sformatf("v%0d.wen", i), {28'h0, SRAMWEN}, {28'h0, tbl[i].wen});
      if (tbl[i].cs)       chk($sformatf("v%0d.addr", i),   {16'h0, SRAMADDR}, {16'h0, tbl[i].sa});
      if (|tbl[i].wen)     chk($sformatf("v%0d.wdata", i),  SRAMWDATA, tbl[i].swd);
      if (tbl[i].chk_rd)   chk($sformatf("v%0d.hrdata", i), HRDATA, tbl[i].rd);
    end

    // Reset lands in the data phase of a write: the write must be dropped.
    @(posedge HCLK);
    #1;
    drive(1, 1, NS, 1, SW, 18'h70, 32'h0);
    @(posedge HCLK);
    #1;
    drive(0, 1, ID, 0, SW, 18'h0, 32'hFFFFFFFF);
    #1;
    chk("abort.pre_cs", {31'h0, SRAMCS}, 32'h1);
    nw0 = nwrites;
    HRESETn = 1'b0;
    #1;
    chk("abort.cs",  {31'h0, SRAMCS},  32'h0);
    chk("abort.wen", {28'h0, SRAMWEN}, 32'h0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    drive(1, 1, NS, 0, SW, 18'h70, 32'h0);
    @(posedge HCLK);
    #1;
    drive(0, 1, ID, 0, SW, 18'h0, 32'h0);
    @(negedge HCLK);
    chk("abort.hrdata",  HRDATA, 32'h0BADF00D);
    chk("abort.nwrites", nwrites, nw0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
